// File: rtl/issue_buffer_pkg.sv
// ============================================================================
// Module   : issue_buffer_pkg
// Purpose  : Shared types and defaults for the dual-issue instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_buffer_pkg;

    localparam int ISSUE_DEPTH = 8;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_WIDTH   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

    typedef struct packed {
        reg_data_t pc;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      rs_en;
        logic      rt_en;
        reg_addr_t rd;
        logic      we;
    } issue_entry_t;

endpackage

`default_nettype wire

// File: rtl/issue_pair_check.sv
// ============================================================================
// Module   : issue_pair_check
// Purpose  : Decides whether the second issue candidate must wait because it
//            reads or rewrites the first candidate's destination register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_pair_check
    import issue_buffer_pkg::*;
(
    input  issue_entry_t head,
    input  issue_entry_t next,
    output logic         blocked
);

    logic w_unused;

    // Writes to r0 are discarded by the regfile, so they never create a hazard.
    always_comb begin
        blocked = 1'b0;
        if (head.we && (head.rd != '0)) begin
            blocked = (next.rs_en && (next.rs == head.rd)) ||
                      (next.rt_en && (next.rt == head.rd)) ||
                      (next.we    && (next.rd == head.rd));
        end
    end

    assign w_unused = ^{head.pc, head.rs, head.rt, head.rs_en, head.rt_en, next.pc};

endmodule

`default_nettype wire

// File: rtl/issue_buffer.sv
// ============================================================================
// Module   : issue_buffer
// Purpose  : Circular buffer between decode and register-read; accepts two
//            instructions per cycle and issues up to two in order.
//            Macro DUAL_ISSUE_EN enables the second issue slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic [1:0]  in_valid,
    input  logic [63:0] in_pc,
    input  logic [9:0]  in_rs,
    input  logic [9:0]  in_rt,
    input  logic [1:0]  in_rs_en,
    input  logic [1:0]  in_rt_en,
    input  logic [9:0]  in_rd,
    input  logic [1:0]  in_we,
    output logic        in_ready,
    output logic [3:0]  read_ena,
    output logic [19:0] read_addr,
    output logic [1:0]  iss_valid,
    output logic [63:0] iss_pc,
    output logic [9:0]  iss_rd,
    output logic [1:0]  iss_we
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    issue_entry_t           mem_q [DEPTH];
    issue_entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    issue_entry_t           w_in_e   [2];
    issue_entry_t           w_slot_e [2];
    logic [PTR_W-1:0]       w_tail1;
    logic [1:0]             w_push_n;
    logic [1:0]             w_pop_n;

    genvar k;
    for (k = 0; k < 2; k++) begin : g_in_slot
        assign w_in_e[k] = {in_pc[32*k +: 32], in_rs[5*k +: 5], in_rt[5*k +: 5],
                            in_rs_en[k], in_rt_en[k], in_rd[5*k +: 5], in_we[k]};
    end

    assign in_ready     = (count_q <= CNT_W'(DEPTH - 2));
    assign w_slot_e[0]  = mem_q[head_q];
    assign iss_valid[0] = !stall && (count_q != '0);

`ifdef DUAL_ISSUE_EN
    logic [PTR_W-1:0] w_head1;
    logic             w_blocked;

    assign w_head1     = head_q + PTR_W'(1);
    assign w_slot_e[1] = mem_q[w_head1];

    issue_pair_check u_pair_check (
        .head    (w_slot_e[0]),
        .next    (w_slot_e[1]),
        .blocked (w_blocked)
    );

    assign iss_valid[1] = iss_valid[0] && (count_q >= CNT_W'(2)) && !w_blocked;
`else
    assign w_slot_e[1]  = '0;
    assign iss_valid[1] = 1'b0;
`endif

    // Unissued slots present all-zero fields so the regfile sees no reads.
    for (k = 0; k < 2; k++) begin : g_iss_slot
        assign iss_pc[32*k +: 32]     = iss_valid[k] ? w_slot_e[k].pc : '0;
        assign iss_rd[5*k +: 5]       = iss_valid[k] ? w_slot_e[k].rd : '0;
        assign iss_we[k]              = iss_valid[k] & w_slot_e[k].we;
        assign read_ena[2*k]          = iss_valid[k] & w_slot_e[k].rs_en;
        assign read_ena[2*k+1]        = iss_valid[k] & w_slot_e[k].rt_en;
        assign read_addr[10*k +: 5]   = read_ena[2*k]   ? w_slot_e[k].rs : '0;
        assign read_addr[10*k+5 +: 5] = read_ena[2*k+1] ? w_slot_e[k].rt : '0;
    end

    assign w_tail1  = tail_q + PTR_W'(1);
    assign w_push_n = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
    assign w_pop_n  = {1'b0, iss_valid[0]} + {1'b0, iss_valid[1]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (in_ready && in_valid[0]) begin
                mem_d[tail_q] = w_in_e[0];
            end
            if (in_ready && in_valid[1]) begin
                mem_d[w_tail1] = w_in_e[1];
            end
            tail_d  = tail_q + PTR_W'(w_push_n);
            head_d  = head_q + PTR_W'(w_pop_n);
            count_d = count_q + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_buffer.sv
// ============================================================================
// Module   : tb_issue_buffer
// Purpose  : Self-checking bench for issue_buffer against a queue-based model.
//            Follows DUAL_ISSUE_EN to select single- or dual-issue expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_buffer;

    localparam int DEPTH = 8;
`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rs_en;
        logic        rt_en;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [9:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_rs_en, in_rt_en, in_we;
    logic        in_ready;
    logic [3:0]  read_ena;
    logic [19:0] read_addr;
    logic [1:0]  iss_valid;
    logic [63:0] iss_pc;
    logic [9:0]  iss_rd;
    logic [1:0]  iss_we;

    ent_t         q[$];
    ent_t         cur0, cur1, zero_e;
    logic [31:0]  pc_ctr = 32'h1000;
    int           tests_run = 0;
    int           tests_failed = 0;
    logic [102:0] exp_b;
    wire  [102:0] obs_b = {in_ready, iss_valid, iss_pc, iss_rd, iss_we, read_ena, read_addr};

    issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt),
        .in_rs_en(in_rs_en), .in_rt_en(in_rt_en), .in_rd(in_rd), .in_we(in_we),
        .in_ready(in_ready), .read_ena(read_ena), .read_addr(read_addr),
        .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_rd(iss_rd), .iss_we(iss_we)
    );

    always #5 clk = ~clk;

    function automatic bit dep(ent_t a, ent_t b);
        if (!a.we || a.rd == 5'd0) return 1'b0;
        return (b.rs_en && b.rs == a.rd) || (b.rt_en && b.rt == a.rd) || (b.we && b.rd == a.rd);
    endfunction

    // Expected outputs derived from the queue contents and the current stall.
    function automatic logic [102:0] model_out();
        logic        r;
        logic [1:0]  v;
        logic [63:0] pc;
        logic [9:0]  rd;
        logic [1:0]  we;
        logic [3:0]  ena;
        logic [19:0] addr;
        ent_t        e;
        r = (DEPTH - q.size()) >= 2;
        v = '0; pc = '0; rd = '0; we = '0; ena = '0; addr = '0;
        if (!stall && q.size() >= 1) v[0] = 1'b1;
        if (DUAL && v[0] && q.size() >= 2) begin
            if (!dep(q[0], q[1])) v[1] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (v[k]) begin
                e = q[k];
                pc[32*k +: 32]     = e.pc;
                rd[5*k +: 5]       = e.rd;
                we[k]              = e.we;
                ena[2*k]           = e.rs_en;
                ena[2*k+1]         = e.rt_en;
                addr[10*k +: 5]    = e.rs_en ? e.rs : 5'd0;
                addr[10*k+5 +: 5]  = e.rt_en ? e.rt : 5'd0;
            end
        end
        return {r, v, pc, rd, we, ena, addr};
    endfunction

    task automatic tick();
        logic [102:0] b;
        int           n;
        b = model_out();
        n = int'(b[101]) + int'(b[100]);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            repeat (n) void'(q.pop_front());
            if (b[102]) begin
                if (in_valid[0]) q.push_back(cur0);
                if (in_valid[1]) q.push_back(cur1);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1);
        cur0 = e0; cur1 = e1;
        in_valid = v;
        in_pc    = {e1.pc, e0.pc};
        in_rs    = {e1.rs, e0.rs};
        in_rt    = {e1.rt, e0.rt};
        in_rs_en = {e1.rs_en, e0.rs_en};
        in_rt_en = {e1.rt_en, e0.rt_en};
        in_rd    = {e1.rd, e0.rd};
        in_we    = {e1.we, e0.we};
    endtask

    task automatic mk(output ent_t e, input logic [4:0] rs, input logic rs_en,
                      input logic [4:0] rt, input logic rt_en, input logic [4:0] rd, input logic we);
        pc_ctr = pc_ctr + 32'd4;
        e = '{pc: pc_ctr, rs: rs, rt: rt, rs_en: rs_en, rt_en: rt_en, rd: rd, we: we};
    endtask

    task automatic new_ent(output ent_t e);
        mk(e, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        ent_t e0, e1;
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        drive(2'b00, zero_e, zero_e);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || iss_valid !== 2'b00 || read_ena !== 4'b0000 || read_addr !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b ena=%b addr=%h, required 1 00 0000 00000",
                     in_ready, iss_valid, read_ena, read_addr);
        end
        mk(e0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        mk(e1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
        drive(2'b11, e0, e1);
        tick();
        rst = 1'b1;
        drive(2'b00, zero_e, zero_e);
        tick();
        rst = 1'b0;
        #1;
        exp_b = model_out();
        tests_run++;
        if (obs_b !== exp_b || iss_valid !== 2'b00 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got %h required %h", obs_b, exp_b);
        end
    endtask

    task automatic test_indep_pair();
        ent_t e0, e1;
        mk(e0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        mk(e1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1);
        drive(2'b11, e0, e1);
        #1;
        tests_run++;
        if (iss_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL indep_no_bypass: valid=%b required 00", iss_valid);
        end
        tick();
        drive(2'b00, zero_e, zero_e);
        #1;
        tests_run++;
        if (iss_valid !== (DUAL ? 2'b11 : 2'b01) ||
            read_addr !== (DUAL ? {5'd6, 5'd5, 5'd2, 5'd1} : {10'd0, 5'd2, 5'd1}) ||
            read_ena  !== (DUAL ? 4'b1111 : 4'b0011)) begin
            tests_failed++;
            $display("FAIL indep_pair: valid=%b addr=%h ena=%b", iss_valid, read_addr, read_ena);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL indep_drain: got %h required %h", obs_b, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_raw_pair();
        ent_t e0, e1;
        mk(e0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
        mk(e1, 5'd7, 1'b1, 5'd9, 1'b0, 5'd8, 1'b1);
        drive(2'b11, e0, e1);
        tick();
        drive(2'b00, zero_e, zero_e);
        #1;
        exp_b = model_out();
        tests_run++;
        if (iss_valid !== 2'b01 || obs_b !== exp_b) begin
            tests_failed++;
            $display("FAIL raw_cycle1: valid=%b got %h required %h", iss_valid, obs_b, exp_b);
        end
        tick();
        #1;
        tests_run++;
        if (iss_valid !== 2'b01 || iss_pc[31:0] !== e1.pc || read_addr[4:0] !== 5'd7) begin
            tests_failed++;
            $display("FAIL raw_cycle2: valid=%b pc=%h required 01 %h", iss_valid, iss_pc[31:0], e1.pc);
        end
        tick();
    endtask

    task automatic test_r0_pair();
        ent_t e0, e1;
        mk(e0, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        mk(e1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        drive(2'b11, e0, e1);
        tick();
        drive(2'b00, zero_e, zero_e);
        #1;
        tests_run++;
        if (iss_valid !== (DUAL ? 2'b11 : 2'b01) || iss_pc[31:0] !== e0.pc) begin
            tests_failed++;
            $display("FAIL r0_pair: valid=%b pc0=%h", iss_valid, iss_pc[31:0]);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            tick();
        end
    endtask

    task automatic test_fill_wrap();
        ent_t e0, e1;
        int   n_iss;
        stall = 1'b1;
        for (int i = 0; i < 8 && q.size() < DEPTH - 1; i++) begin
            new_ent(e0); new_ent(e1);
            drive((i == 0) ? 2'b01 : 2'b11, e0, e1);
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL fill: got %h required %h", obs_b, exp_b);
            end
            tick();
        end
        new_ent(e0); new_ent(e1);
        drive(2'b11, e0, e1);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        stall = 1'b0;
        drive(2'b00, zero_e, zero_e);
        n_iss = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL wrap_drain: got %h required %h", obs_b, exp_b);
            end
            n_iss += int'(iss_valid[0]) + int'(iss_valid[1]);
            tick();
        end
        tests_run++;
        if (n_iss !== DEPTH - 1) begin
            tests_failed++;
            $display("FAIL wrap_count: issued %0d required %0d", n_iss, DEPTH - 1);
        end
    endtask

    task automatic test_flush();
        ent_t e0, e1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_ent(e0); new_ent(e1);
            drive((i == 2) ? 2'b01 : 2'b11, e0, e1);
            tick();
        end
        flush = 1'b1;
        new_ent(e0); new_ent(e1);
        drive(2'b11, e0, e1);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(2'b00, zero_e, zero_e);
        #1;
        exp_b = model_out();
        tests_run++;
        if (in_ready !== 1'b1 || iss_valid !== 2'b00 || obs_b !== exp_b) begin
            tests_failed++;
            $display("FAIL flush: ready=%b valid=%b got %h required %h", in_ready, iss_valid, obs_b, exp_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ent_t e0, e1;
        int   n_iss;
        stall = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin
            mk(e0, 5'd20, 1'b0, 5'd21, 1'b0, 5'd10, 1'b1);
            mk(e1, 5'd22, 1'b0, 5'd23, 1'b0, 5'd11, 1'b1);
            drive(2'b11, e0, e1);
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL b2b: got %h required %h", obs_b, exp_b);
            end
            n_iss += int'(iss_valid[0]) + int'(iss_valid[1]);
            tick();
        end
        tests_run++;
        if (n_iss !== (DUAL ? 18 : 9)) begin
            tests_failed++;
            $display("FAIL b2b_throughput: issued %0d required %0d", n_iss, DUAL ? 18 : 9);
        end
        drive(2'b00, zero_e, zero_e);
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            tick();
        end
    endtask

    task automatic test_random();
        ent_t e0, e1;
        int   sel;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 29) == 0);
            stall = ($urandom_range(0, 3) == 0);
            sel   = $urandom_range(0, 2);
            new_ent(e0); new_ent(e1);
            drive((sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11, e0, e1);
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got %h required %h", i, obs_b, exp_b);
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(2'b00, zero_e, zero_e);
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            #1; exp_b = model_out(); tests_run++;
            if (obs_b !== exp_b) begin
                tests_failed++;
                $display("FAIL random_drain: got %h required %h", obs_b, exp_b);
            end
            tick();
        end
    endtask

    initial begin
        zero_e = '0;
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        drive(2'b00, zero_e, zero_e);
        @(negedge clk);
        test_reset();
        test_indep_pair();
        test_raw_pair();
        test_r0_pair();
        test_fill_wrap();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
